instruction_fetch: RTL and testbench

Fetch stage directly downstream of the program counter. It samples the current PC, runs a request/acknowledge read of word-addressed instruction memory, and holds the returned word in an instruction register for the decoder under a valid/ready handshake. It raises `pc_inc` so the control unit can select PS=01 (PC <- PC+1). It discards in-flight data on a branch/jump flush and latches a sticky error if memory never acknowledges.

---
 rtl/cpu_fetch_pkg.sv | 23 ++
 rtl/fetch_watchdog.sv | 38 +++
 rtl/instruction_fetch.sv | 136 +++++++++++++
 tb/tb_instruction_fetch.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package cpu_fetch_pkg;

    localparam int unsigned ADDR_W_DEF      = 32;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned ACK_TIMEOUT_DEF = 256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_FULL    = 3'd2,
        ST_RESTART = 3'd3,
        ST_ERR     = 3'd4
    } state_e;

    // Watchdog counter width; at least one bit even for tiny timeouts.
    function automatic int unsigned wd_width(input int unsigned timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

    localparam int unsigned WD_W_DEF = wd_width(ACK_TIMEOUT_DEF);

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive un-acknowledged request cycles and flags the timeout.
module fetch_watchdog
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int unsigned WD_W = wd_width(ACK_TIMEOUT);

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == WD_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: samples the PC, reads instruction memory with req/ack and
// presents the word to the decoder through a valid/ready instruction register.
module instruction_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_inc,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              fetch_err
);

    state_e            state_q,    state_d;
    logic              discard_q,  discard_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_q,       ir_d;
    logic [ADDR_W-1:0] ir_pc_q,    ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic              wd_expired;

    // Watchdog is held clear outside REQ, so every REQ entry starts from zero.
    fetch_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != ST_REQ),
        .en      ((state_q == ST_REQ) && !mem_ack),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            discard_q   <= 1'b0;
            mem_addr_q  <= '0;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            discard_q   <= discard_d;
            mem_addr_q  <= mem_addr_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Next state: timeout beats flush, flush beats ack/ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_RESTART: state_d = flush ? ST_RESTART : ST_REQ;
            ST_REQ: begin
                if (wd_expired) begin
                    state_d = ST_ERR;
                end else if (mem_ack) begin
                    state_d = (discard_q || flush) ? ST_RESTART : ST_FULL;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    state_d = ST_RESTART;
                end else if (ir_ready) begin
                    state_d = ST_REQ;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        discard_d   = discard_q;
        mem_addr_d  = mem_addr_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        fetch_err_d = fetch_err_q;
        pc_inc      = 1'b0;
        mem_req     = (state_q == ST_REQ);

        // The request address is captured only on REQ entry and frozen inside it.
        if ((state_q != ST_REQ) && (state_d == ST_REQ)) begin
            mem_addr_d = pc;
        end

        unique case (state_q)
            ST_REQ: begin
                if (wd_expired) begin
                    fetch_err_d = 1'b1;
                end else if (mem_ack) begin
                    discard_d = 1'b0;
                    if (!discard_q && !flush) begin
                        ir_d       = mem_rdata;
                        ir_pc_d    = mem_addr_q;
                        ir_valid_d = 1'b1;
                        pc_inc     = !rst;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            ST_FULL: begin
                if (flush || ir_ready) begin
                    ir_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a per-cycle vector table plus
// hand-written timeout and reset-mid-request sequences.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        flush = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        ir_ready = 1'b0;
    logic        pc_inc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .pc_inc    (pc_inc),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .fetch_err (fetch_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_inc;
        logic [31:0] e_ir;
        logic [31:0] e_irpc;
        logic        e_valid;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] p, input logic f, input logic a, input logic [31:0] d,
                       input logic r, input logic e_req, input logic [31:0] e_addr,
                       input logic e_inc, input logic [31:0] e_ir, input logic [31:0] e_irpc,
                       input logic e_valid, input logic e_err);
        vec_t v;
        v.pc = p; v.flush = f; v.ack = a; v.rdata = d; v.ready = r;
        v.e_req = e_req; v.e_addr = e_addr; v.e_inc = e_inc; v.e_ir = e_ir;
        v.e_irpc = e_irpc; v.e_valid = e_valid; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "bench time limit");
    end

    initial begin
        // pc flush ack rdata ready | req addr inc ir ir_pc valid err
        add(32'h800,  0, 0, 32'h0,        0, 0, 32'h0,    0, 32'h0,        32'h0,    0, 0); // IDLE
        add(32'h800,  0, 0, 32'h0,        0, 1, 32'h800,  0, 32'h0,        32'h0,    0, 0); // REQ 1
        add(32'h800,  0, 1, 32'hDEADBEEF, 0, 1, 32'h800,  1, 32'h0,        32'h0,    0, 0); // REQ 2 ack
        add(32'h801,  0, 0, 32'h0,        0, 0, 32'h800,  0, 32'hDEADBEEF, 32'h800,  1, 0); // FULL
        add(32'h801,  0, 0, 32'h0,        0, 0, 32'h800,  0, 32'hDEADBEEF, 32'h800,  1, 0); // hold
        add(32'h801,  0, 0, 32'h0,        1, 0, 32'h800,  0, 32'hDEADBEEF, 32'h800,  1, 0); // ready
        add(32'h801,  0, 1, 32'h12345678, 0, 1, 32'h801,  1, 32'hDEADBEEF, 32'h800,  0, 0); // REQ ack
        add(32'h800,  0, 0, 32'h0,        1, 0, 32'h801,  0, 32'h12345678, 32'h801,  1, 0); // FULL ready
        add(32'h800,  1, 0, 32'h0,        0, 1, 32'h800,  0, 32'h12345678, 32'h801,  0, 0); // flush in REQ
        add(32'h2000, 0, 0, 32'h0,        0, 1, 32'h800,  0, 32'h12345678, 32'h801,  0, 0);
        add(32'h2000, 0, 0, 32'h0,        0, 1, 32'h800,  0, 32'h12345678, 32'h801,  0, 0);
        add(32'h2000, 0, 1, 32'h00000BAD, 0, 1, 32'h800,  0, 32'h12345678, 32'h801,  0, 0); // dropped ack
        add(32'h2000, 0, 0, 32'h0,        0, 0, 32'h800,  0, 32'h12345678, 32'h801,  0, 0); // RESTART
        add(32'h2000, 0, 1, 32'hCAFE0001, 0, 1, 32'h2000, 1, 32'h12345678, 32'h801,  0, 0); // REQ ack
        add(32'h2001, 1, 0, 32'h0,        1, 0, 32'h2000, 0, 32'hCAFE0001, 32'h2000, 1, 0); // flush+ready
        add(32'h3000, 0, 0, 32'h0,        0, 0, 32'h2000, 0, 32'hCAFE0001, 32'h2000, 0, 0); // RESTART
        add(32'h3000, 1, 1, 32'h00005555, 0, 1, 32'h3000, 0, 32'hCAFE0001, 32'h2000, 0, 0); // flush+ack
        add(32'h3100, 0, 0, 32'h0,        0, 0, 32'h3000, 0, 32'hCAFE0001, 32'h2000, 0, 0); // RESTART
        add(32'h3100, 0, 0, 32'h0,        0, 1, 32'h3100, 0, 32'hCAFE0001, 32'h2000, 0, 0); // REQ

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            pc = vecs[i].pc; flush = vecs[i].flush; mem_ack = vecs[i].ack;
            mem_rdata = vecs[i].rdata; ir_ready = vecs[i].ready;
            #1;
            check($sformatf("v%0d mem_req", i),   32'(mem_req),   32'(vecs[i].e_req));
            check($sformatf("v%0d mem_addr", i),  mem_addr,       vecs[i].e_addr);
            check($sformatf("v%0d pc_inc", i),    32'(pc_inc),    32'(vecs[i].e_inc));
            check($sformatf("v%0d ir", i),        ir,             vecs[i].e_ir);
            check($sformatf("v%0d ir_pc", i),     ir_pc,          vecs[i].e_irpc);
            check($sformatf("v%0d ir_valid", i),  32'(ir_valid),  32'(vecs[i].e_valid));
            check($sformatf("v%0d fetch_err", i), 32'(fetch_err), 32'(vecs[i].e_err));
        end

        // Timeout: eight un-acked REQ cycles, then ERR ignores ack and flush.
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0; pc = 32'h4000;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("to idle mem_req", 32'(mem_req), 32'd0);
        check("to idle ir", ir, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            check($sformatf("to req%0d mem_req", i), 32'(mem_req), 32'd1);
            check($sformatf("to req%0d fetch_err", i), 32'(fetch_err), 32'd0);
        end
        @(negedge clk); #1;
        check("to err fetch_err", 32'(fetch_err), 32'd1);
        check("to err mem_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b1; flush = 1'b1; mem_rdata = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check($sformatf("err hold%0d fetch_err", i), 32'(fetch_err), 32'd1);
            check($sformatf("err hold%0d mem_req", i), 32'(mem_req), 32'd0);
            check($sformatf("err hold%0d pc_inc", i), 32'(pc_inc), 32'd0);
            check($sformatf("err hold%0d ir_valid", i), 32'(ir_valid), 32'd0);
        end

        // Reset clears ERR; then reset lands on a REQ cycle that carries an ack.
        mem_ack = 1'b0; flush = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst fetch_err", 32'(fetch_err), 32'd0);
        check("rst idle mem_req", 32'(mem_req), 32'd0);
        @(negedge clk); #1;
        check("rr req mem_req", 32'(mem_req), 32'd1);
        check("rr req mem_addr", mem_addr, 32'h4000);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        #1;
        check("rr pc_inc", 32'(pc_inc), 32'd1);
        @(negedge clk);
        mem_ack = 1'b0; ir_ready = 1'b1;
        #1;
        check("rr full ir", ir, 32'hA5A5A5A5);
        check("rr full ir_valid", 32'(ir_valid), 32'd1);
        @(negedge clk);
        ir_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11111111; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0;
        #1;
        check("rm ir", ir, 32'h0);
        check("rm ir_pc", ir_pc, 32'h0);
        check("rm ir_valid", 32'(ir_valid), 32'd0);
        check("rm mem_addr", mem_addr, 32'h0);
        check("rm mem_req", 32'(mem_req), 32'd0);
        check("rm pc_inc", 32'(pc_inc), 32'd0);
        @(negedge clk); #1;
        check("rm next mem_req", 32'(mem_req), 32'd1);
        check("rm next ir", ir, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
